// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: FSM state encoding,
// the fill pattern returned on a bus timeout, and an alignment helper.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        DMB_IDLE = 2'd0,
        DMB_REQ  = 2'd1,
        DMB_DONE = 2'd2
    } dmb_state_e;

    localparam logic [31:0] DMB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // A word access is legal only when the two byte-offset bits are zero.
    function automatic logic dmb_word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Bus wait-cycle counter for the data-memory bridge. Cleared when a bus
// request is launched, advanced on every request cycle without ack.
// expired_o is high during the wait cycle that completes the limit.
module dmem_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    // The limit is hit in the wait cycle whose count, once incremented,
    // would equal TIMEOUT_CYCLES; this gives exactly TIMEOUT_CYCLES REQ cycles.
    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q;

    // Wait counter: clear on launch, count unacknowledged request cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LAST_WAIT);

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the single-cycle datapath's load/store port
// into a req/ack transaction on a variable-latency bus, stalling the
// datapath until the bus completes. Misaligned word accesses are trapped
// without any bus traffic.
// Optional feature: define MEM_TIMEOUT_EN to bound the bus wait with a
// TIMEOUT_CYCLES limit (forced completion with DEAD_BEEF and timeout_err).
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        cpu_rst,
    input  logic        cpu_en,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Elaboration-time sanity check on the counter width.
    if (TIMEOUT_W < 1 || TIMEOUT_W > 30 || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
        $error("dmem_bridge: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    dmb_state_e  state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        misalign_q;

    logic        access;
    logic        aligned;
    logic        launch;
    logic        in_req;
    logic [31:0] bus_addr_d;
    logic        timeout_hit;

    assign access     = cpu_en & (mem_ren | mem_wen);
    assign aligned    = dmb_word_aligned(mem_addr[1:0]);
    assign in_req     = (state_q == DMB_REQ);
    assign launch     = (state_q == DMB_IDLE) & access & aligned;
    assign bus_addr_d = {mem_addr[31:2], 2'b00};

`ifdef MEM_TIMEOUT_EN
    logic timeout_q;
    logic cnt_expired;

    dmem_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (cpu_rst),
        .clear_i   (launch),
        .count_i   (in_req & ~bus_ack),
        .expired_o (cnt_expired)
    );

    // An ack arriving in the expiry cycle is a normal completion.
    assign timeout_hit = in_req & ~bus_ack & cnt_expired;
    assign timeout_err = timeout_q;

    // One-cycle timeout pulse, raised on the forced-completion edge.
    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Bridge FSM: detect in IDLE, hold the request in REQ, one DONE cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            // NOTE: the read buffer is a plain register (not a memory array),
            // so it is reset like any other state and mem_din reads 0 after reset.
            state_q     <= DMB_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                DMB_IDLE: begin
                    if (access) begin
                        if (!aligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            // Store wins when both requests are raised together.
                            bus_we_q    <= mem_wen;
                            bus_addr_q  <= bus_addr_d;
                            bus_wdata_q <= mem_dout;
                            bus_req_q   <= 1'b1;
                            state_q     <= DMB_REQ;
                        end
                    end
                end
                DMB_REQ: begin
                    if (bus_ack) begin
                        if (!bus_we_q) begin
                            rdata_q <= bus_rdata;
                        end
                        bus_req_q <= 1'b0;
                        state_q   <= DMB_DONE;
                    end else if (timeout_hit) begin
                        rdata_q   <= DMB_TIMEOUT_DATA;
                        bus_req_q <= 1'b0;
                        state_q   <= DMB_DONE;
                    end
                end
                DMB_DONE: begin
                    // The still-held datapath request is not re-issued here.
                    state_q <= DMB_IDLE;
                end
                default: begin
                    state_q <= DMB_IDLE;
                end
            endcase
        end
    end

    assign mem_stall    = launch | in_req;
    assign mem_din      = rdata_q;
    assign misalign_err = misalign_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge. A transaction-timeline model sets the
// expected outputs for every cycle; one compare process checks them on the
// falling edge, and literal checks pin the model to hand-computed values.
module tb_dmem_bridge;

    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        cpu_en = 1'b0;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_dout = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic [31:0] mem_din;
    logic        mem_stall;
    logic        misalign_err;
    logic        timeout_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_we = 1'b0;
    logic        exp_mis = 1'b0;
    logic        exp_to = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_din = '0;

    // Observed activity counters (written only by the compare process).
    int stall_cnt = 0;
    int req_cnt = 0;
    int mis_cnt = 0;
    int s0, r0, m0;

    dmem_bridge #(
        .TIMEOUT_CYCLES (TO_CYC),
        .TIMEOUT_W      (8)
    ) dut (
        .clk          (clk),
        .cpu_rst      (cpu_rst),
        .cpu_en       (cpu_en),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_stall    (mem_stall),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_stall", 32'(mem_stall), 32'(exp_stall));
            check("bus_req", 32'(bus_req), 32'(exp_req));
            check("mem_din", mem_din, exp_din);
            check("misalign_err", 32'(misalign_err), 32'(exp_mis));
            check("timeout_err", 32'(timeout_err), 32'(exp_to));
            if (exp_req) begin
                check("bus_addr", bus_addr, exp_addr);
                check("bus_we", 32'(bus_we), 32'(exp_we));
                if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
            end
            if (mem_stall) stall_cnt++;
            if (bus_req) req_cnt++;
            if (misalign_err) mis_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One aligned access: detect cycle, waits+1 REQ cycles, one DONE cycle.
    // Returns in the cycle after DONE with the datapath request dropped.
    task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] dout, input int waits,
                          input logic [31:0] rdata, input bit give_ack);
        cpu_en = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
        bus_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_mis = 1'b0; exp_to = 1'b0;
        step();
        for (int k = 0; k <= waits; k++) begin
            exp_req = 1'b1; exp_stall = 1'b1; exp_we = wen; exp_addr = addr; exp_wdata = dout;
            if (k == 1) cpu_en = 1'b0;   // enable loss must not abort the transaction
            if (give_ack && k == waits) begin
                bus_ack = 1'b1; bus_rdata = rdata;
            end else begin
                bus_ack = 1'b0; bus_rdata = $urandom;
            end
            step();
        end
        bus_ack = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0;
        if (!give_ack) begin
            exp_din = 32'hDEAD_BEEF; exp_to = 1'b1;
        end else if (!wen) begin
            exp_din = rdata;
        end
        step();
        mem_ren = 1'b0; mem_wen = 1'b0; cpu_en = 1'b1; exp_to = 1'b0;
    endtask

    task automatic misaligned(input logic ren, input logic wen, input logic [31:0] addr);
        cpu_en = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = addr;
        exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0;
        step();
        mem_ren = 1'b0; mem_wen = 1'b0; exp_mis = 1'b1;
        step();
        exp_mis = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        #1 cpu_rst = 1'b1;
        #2;
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        step();
        step();
        cpu_rst = 1'b0; cpu_en = 1'b1; chk_en = 1'b1;
        step();

        // Load, ack on first REQ cycle
        s0 = stall_cnt; r0 = req_cnt;
        access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h1234_5678, 1'b1);
        check("load_stall_cycles", 32'(stall_cnt - s0), 32'd2);
        check("load_req_cycles", 32'(req_cnt - r0), 32'd1);
        check("load_din", mem_din, 32'h1234_5678);

        // Stray ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        step();
        bus_ack = 1'b0;
        step();
        check("idle_ack_din", mem_din, 32'h1234_5678);

        // Store, ack after 3 wait cycles
        s0 = stall_cnt; r0 = req_cnt;
        access(1'b0, 1'b1, 32'h20, 32'hCAFE_0001, 3, 32'h5555_AAAA, 1'b1);
        check("store_stall_cycles", 32'(stall_cnt - s0), 32'd5);
        check("store_req_cycles", 32'(req_cnt - r0), 32'd4);
        check("store_din_kept", mem_din, 32'h1234_5678);

        // Misaligned load and store
        s0 = stall_cnt; r0 = req_cnt; m0 = mis_cnt;
        misaligned(1'b1, 1'b0, 32'h13);
        check("misalign_pulses", 32'(mis_cnt - m0), 32'd1);
        misaligned(1'b0, 1'b1, 32'h22);
        check("misalign_pulses2", 32'(mis_cnt - m0), 32'd2);
        check("misalign_no_req", 32'(req_cnt - r0), 32'd0);
        check("misalign_no_stall", 32'(stall_cnt - s0), 32'd0);

        // Load and store together: only the write goes out
        r0 = req_cnt;
        access(1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 1, 32'hFFFF_FFFF, 1'b1);
        check("both_req_cycles", 32'(req_cnt - r0), 32'd2);
        check("both_din_kept", mem_din, 32'h1234_5678);

        // Access with cpu_en low is not accepted
        cpu_en = 1'b0; mem_ren = 1'b1; mem_addr = 32'h50;
        exp_stall = 1'b0; exp_req = 1'b0;
        step();
        mem_ren = 1'b0; cpu_en = 1'b1;
        step();

        // Back-to-back loads
        r0 = req_cnt;
        access(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'hA5A5_0001, 1'b1);
        check("b2b_first_din", mem_din, 32'hA5A5_0001);
        access(1'b1, 1'b0, 32'h48, 32'h0, 0, 32'h0F0F_F0F0, 1'b1);
        check("b2b_second_din", mem_din, 32'h0F0F_F0F0);
        check("b2b_req_cycles", 32'(req_cnt - r0), 32'd3);

`ifdef MEM_TIMEOUT_EN
        // No ack: forced completion after TO_CYC request cycles
        r0 = req_cnt;
        access(1'b1, 1'b0, 32'h60, 32'h0, TO_CYC - 1, 32'h0, 1'b0);
        check("timeout_req_cycles", 32'(req_cnt - r0), 32'd4);
        check("timeout_din", mem_din, 32'hDEAD_BEEF);
        // Ack in the expiry cycle wins
        access(1'b1, 1'b0, 32'h64, 32'h0, TO_CYC - 1, 32'h7777_0000, 1'b1);
        check("expiry_ack_din", mem_din, 32'h7777_0000);
`endif

        // Reset two cycles into REQ
        cpu_en = 1'b1; mem_ren = 1'b1; mem_addr = 32'h40;
        exp_stall = 1'b1; exp_req = 1'b0;
        step();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h40;
        step();
        step();
        #2;
        chk_en = 1'b0;
        mem_ren = 1'b0;
        cpu_rst = 1'b1;
        #1;
        check("rst_mid_bus_req", 32'(bus_req), 32'h0);
        check("rst_mid_stall", 32'(mem_stall), 32'h0);
        check("rst_mid_din", mem_din, 32'h0);
        step();
        cpu_rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        exp_stall = 1'b0; exp_req = 1'b0; exp_din = 32'h0; exp_mis = 1'b0; exp_to = 1'b0;
        chk_en = 1'b1;
        step();
        bus_ack = 1'b0;
        step();
        check("late_ack_din", mem_din, 32'h0);
        check("late_ack_req", 32'(bus_req), 32'h0);
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle datapath's memory port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Converts each one-cycle load/store into a req/ack transaction on a variable-latency data bus.
- Returns read data and drives a stall back to the datapath so PC, register write and the memory request hold until the bus completes.
- Traps misaligned word accesses without touching the bus.

Parameters:
TIMEOUT_CYCLES, 255, bus wait-cycle limit before forced completion (used only with MEM_TIMEOUT_EN)
TIMEOUT_W, 8, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  main clock, all state on rising edge
cpu_rst  input  1  asynchronous, active-high reset
cpu_en  input  1  CPU enable; new accesses accepted only when high
mem_ren  input  1  datapath load request
mem_wen  input  1  datapath store request
mem_addr  input  32  datapath byte address
mem_dout  input  32  datapath store data
mem_din  output  32  load data to datapath
mem_stall  output  1  hold datapath PC and writeback this cycle
misalign_err  output  1  one-cycle pulse: rejected misaligned access
timeout_err  output  1  one-cycle pulse: bus timeout (tied 0 without MEM_TIMEOUT_EN)
bus_req  output  1  bus request, registered
bus_we  output  1  1 = write, 0 = read, registered
bus_addr  output  32  word-aligned bus address, registered
bus_wdata  output  32  bus write data, registered
bus_ack  input  1  bus completion, single-cycle pulse
bus_rdata  input  32  read data, valid when bus_ack is high

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - bus_req, bus_we, misalign_err and timeout_err go to 0.
  - bus_addr, bus_wdata and the read buffer go to 0, so mem_din = 0.
  - A reset mid-transaction drops bus_req at once; a late bus_ack after reset is ignored.
- FSM states: IDLE, REQ, DONE.
- Access detect in IDLE: acc = cpu_en & (mem_ren | mem_wen).
  - If mem_addr[1:0] != 0: the access is rejected. misalign_err pulses on the next cycle, no stall, no bus traffic, state stays IDLE.
  - If aligned: latch addr/data/we into the bus registers and go to REQ.
- Store wins over load: if mem_wen and mem_ren are both high, only the write is issued.
- Stall:
  - mem_stall is combinational: (IDLE & acc & aligned) | REQ.
  - It is 0 in DONE, so the datapath advances on the DONE edge.
- REQ state:
  - bus_req = 1, with bus_addr/bus_we/bus_wdata held stable.
  - On bus_ack: a read captures bus_rdata into the read buffer. Clear bus_req and go to DONE.
  - cpu_en low during REQ does not abort; the transaction completes.
- DONE state:
  - One cycle. mem_din = read buffer (still valid for the held load's writeback). Go to IDLE.
  - The datapath request still visible in DONE is not re-issued.
- Latency: minimum 3 cycles per aligned access (IDLE detect, REQ with same-cycle ack, DONE), i.e. 2 stall cycles. Each extra bus wait cycle adds one.
- mem_din outside DONE holds the last captured read value. Writes do not modify it.
- bus_ack outside REQ is ignored.
- Back-to-back: an access asserted in the cycle after DONE (IDLE) starts immediately; there are no bubble requirements.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES and ack is still absent: drop bus_req, load the read buffer with 32'hDEAD_BEEF, pulse timeout_err for 1 cycle, go to DONE.
  - An ack in the same cycle as expiry wins; that is a normal completion with no error.
- Undefined: REQ waits indefinitely; timeout_err is constant 0 and no counter logic is synthesized.

Decomposition:
- Shared constants header (alongside the existing MIPS defines):
  - FSM state encodings DMB_IDLE/DMB_REQ/DMB_DONE (2-bit).
  - DMB_TIMEOUT_DATA = 32'hDEAD_BEEF.
- One natural sub-module: dmem_timeout_cnt (counter + expiry compare), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Load, ack on first REQ cycle: mem_ren=1, addr=0x10, bus_rdata=0x1234_5678 -> bus_req high 1 cycle with bus_addr=0x10, bus_we=0; mem_stall high 2 cycles; mem_din=0x1234_5678 in DONE.
- Store, ack after 3 wait cycles: mem_wen=1, addr=0x20, dout=0xCAFE_0001 -> bus_we=1, bus_wdata=0xCAFE_0001 held 4 cycles; mem_stall high 5 cycles; mem_din unchanged.
- Misaligned: mem_ren=1, addr=0x13 -> no bus_req, mem_stall=0, misalign_err=1 for exactly 1 cycle.
- Both ren and wen high at addr=0x30 -> single write transaction, bus_we=1.
- Reset mid-REQ: assert cpu_rst 2 cycles into REQ -> bus_req=0 immediately (same cycle, asynchronous), state IDLE; bus_ack one cycle later ignored, mem_din=0.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 REQ cycles; timeout_err pulses; mem_din=0xDEAD_BEEF in DONE.
